panel_region_arbiter: RTL and testbench

Configuration controller for the VGA panel's rectangle overlay table. Two requesters (e.g. a UART command decoder and a push-button controller) submit region descriptors through valid/ready ports. The block round-robin arbitrates between them, validates each descriptor and writes it into a staging table. On each rising edge of vertical blanking it copies the staging table into the live table the pixel generator reads, so no frame ever shows a half-updated overlay.

---
 rtl/panel_cfg_pkg.sv | 34 +++
 rtl/rr_arbiter2.sv | 33 +++
 rtl/panel_region_arbiter.sv | 147 ++++++++++++++
 tb/tb_panel_region_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/panel_cfg_pkg.sv
// Shared types and constants for the panel overlay configuration path:
// the region descriptor, panel geometry and the controller state encoding.
package panel_cfg_pkg;

   localparam int REGION_COORD_W = 11;
   localparam int REGION_COLOR_W = 12;

   localparam logic [REGION_COORD_W-1:0] H_VISIBLE = 11'd800;
   localparam logic [REGION_COORD_W-1:0] V_VISIBLE = 11'd600;
   localparam logic [REGION_COORD_W-1:0] H_TOTAL   = 11'd1040;
   localparam logic [REGION_COORD_W-1:0] V_TOTAL   = 11'd666;

   // One overlay rectangle; bounds are inclusive, colour is {r[3:0], g[3:0], b[3:0]}.
   typedef struct packed {
      logic                      en;
      logic [REGION_COORD_W-1:0] x0;
      logic [REGION_COORD_W-1:0] x1;
      logic [REGION_COORD_W-1:0] y0;
      logic [REGION_COORD_W-1:0] y1;
      logic [REGION_COLOR_W-1:0] color;
   } region_t;

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      COMMIT  = 1'b1
   } state_t;

   // A descriptor is usable only if its bounds are ordered and lie inside the visible area.
   function automatic logic region_ok(input region_t r);
      return (r.x0 <= r.x1) && (r.y0 <= r.y1) &&
             (r.x1 < H_VISIBLE) && (r.y1 < V_VISIBLE);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Ready is combinational from the enable and the
// last-served flag; a requester's ready only looks at the other side's valid,
// so it never depends on its own valid.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic a_valid_i,
   input  logic b_valid_i,
   output logic a_ready_o,
   output logic b_ready_o
);

   // 1 means B was served last, so A wins the next tie.
   logic last_b_q;

   assign a_ready_o = !rst && en_i && (!b_valid_i || last_b_q);
   assign b_ready_o = !rst && en_i && (!a_valid_i || !last_b_q);

   // Remember who completed the most recent transfer; idle cycles leave it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b_q <= 1'b1;
      end else if (a_valid_i && a_ready_o) begin
         last_b_q <= 1'b0;
      end else if (b_valid_i && b_ready_o) begin
         last_b_q <= 1'b1;
      end else begin
         last_b_q <= last_b_q;
      end
   end

endmodule

// File: rtl/panel_region_arbiter.sv
// Overlay table controller: arbitrates two descriptor sources into a staging
// table and copies staging into the live table, one entry per cycle, on each
// rising edge of vertical blanking so the pixel path never sees a torn update.
module panel_region_arbiter
   import panel_cfg_pkg::*;
#(
   parameter int N_REGIONS = 4,
   parameter int COORD_W   = REGION_COORD_W,
   parameter int COLOR_W   = REGION_COLOR_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_vblank,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [$clog2(N_REGIONS)-1:0] a_idx,
   input  logic                         a_en,
   input  logic [COORD_W-1:0]           a_x0,
   input  logic [COORD_W-1:0]           a_x1,
   input  logic [COORD_W-1:0]           a_y0,
   input  logic [COORD_W-1:0]           a_y1,
   input  logic [COLOR_W-1:0]           a_color,
   input  logic                         b_valid,
   output logic                         b_ready,
   input  logic [$clog2(N_REGIONS)-1:0] b_idx,
   input  logic                         b_en,
   input  logic [COORD_W-1:0]           b_x0,
   input  logic [COORD_W-1:0]           b_x1,
   input  logic [COORD_W-1:0]           b_y0,
   input  logic [COORD_W-1:0]           b_y1,
   input  logic [COLOR_W-1:0]           b_color,
   output region_t [N_REGIONS-1:0]      live_tbl,
   output logic                         commit_done,
   output logic                         busy,
   output logic                         err_invalid
);

   localparam int IDX_W = $clog2(N_REGIONS);

   state_t                  state_q;
   logic [IDX_W-1:0]        cnt_q;
   logic                    vb_q;
   logic                    dirty_q;
   logic                    commit_done_q;
   logic                    busy_q;
   logic                    err_q;
   region_t [N_REGIONS-1:0] stage_q;
   region_t [N_REGIONS-1:0] live_q;

   logic                    collect;
   logic                    acc_a;
   logic                    acc_b;
   logic                    accept;
   logic                    desc_ok;
   logic                    vb_rise;
   region_t                 desc_d;
   logic [IDX_W-1:0]        idx_d;

   assign collect = (state_q == COLLECT);

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .en_i      (collect),
      .a_valid_i (a_valid),
      .b_valid_i (b_valid),
      .a_ready_o (a_ready),
      .b_ready_o (b_ready)
   );

   assign acc_a   = a_valid && a_ready;
   assign acc_b   = b_valid && b_ready;
   assign accept  = acc_a || acc_b;
   assign vb_rise = in_vblank && !vb_q;
   assign desc_ok = region_ok(desc_d);

   // Steer the granted requester's descriptor onto the write path.
   always_comb begin
      desc_d = '0;
      idx_d  = '0;
      if (acc_a) begin
         desc_d = {a_en, a_x0, a_x1, a_y0, a_y1, a_color};
         idx_d  = a_idx;
      end else begin
         desc_d = {b_en, b_x0, b_x1, b_y0, b_y1, b_color};
         idx_d  = b_idx;
      end
   end

   // Controller FSM: collect and validate writes, then copy staging to live on a vblank rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= COLLECT;
         cnt_q         <= '0;
         vb_q          <= 1'b0;
         dirty_q       <= 1'b0;
         commit_done_q <= 1'b0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         stage_q       <= '0;
         live_q        <= '0;
      end else begin
         vb_q          <= in_vblank;
         commit_done_q <= 1'b0;
         case (state_q)
            COLLECT: begin
               if (accept) begin
                  if (desc_ok) begin
                     stage_q[idx_d] <= desc_d;
                     dirty_q        <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               // A write landing on the rise edge joins this commit.
               if (vb_rise && (dirty_q || (accept && desc_ok))) begin
                  state_q <= COMMIT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            COMMIT: begin
               live_q[cnt_q] <= stage_q[cnt_q];
               if (cnt_q == IDX_W'(N_REGIONS - 1)) begin
                  cnt_q         <= '0;
                  dirty_q       <= 1'b0;
                  commit_done_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= COLLECT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= COLLECT;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign live_tbl    = live_q;
   assign commit_done = commit_done_q;
   assign busy        = busy_q;
   assign err_invalid = err_q;

endmodule

// File: tb/tb_panel_region_arbiter.sv
// Directed bench for panel_region_arbiter: hand-written sequences for reset,
// fairness, commit timing, rejection, empty frames and reset mid-commit, plus
// a table of descriptors exercising the validation bounds.
module tb_panel_region_arbiter;
   import panel_cfg_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_vblank;
   logic a_valid, a_ready, a_en, b_valid, b_ready, b_en;
   logic [1:0]  a_idx, b_idx;
   logic [10:0] a_x0, a_x1, a_y0, a_y1, b_x0, b_x1, b_y0, b_y1;
   logic [11:0] a_color, b_color;
   region_t [3:0] live_tbl;
   logic commit_done, busy, err_invalid;

   int checks = 0;
   int errors = 0;

   panel_region_arbiter #(.N_REGIONS(4), .COORD_W(11), .COLOR_W(12)) dut (
      .clk(clk), .rst(rst), .in_vblank(in_vblank),
      .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_en(a_en),
      .a_x0(a_x0), .a_x1(a_x1), .a_y0(a_y0), .a_y1(a_y1), .a_color(a_color),
      .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_en(b_en),
      .b_x0(b_x0), .b_x1(b_x1), .b_y0(b_y0), .b_y1(b_y1), .b_color(b_color),
      .live_tbl(live_tbl), .commit_done(commit_done), .busy(busy),
      .err_invalid(err_invalid)
   );

   typedef struct {
      string   name;
      region_t d;
      logic    ok;
   } vec_t;

   vec_t vecs[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic region_t mk(input logic en, input logic [10:0] x0, input logic [10:0] x1,
                                  input logic [10:0] y0, input logic [10:0] y1, input logic [11:0] c);
      region_t r;
      r.en = en; r.x0 = x0; r.x1 = x1; r.y0 = y0; r.y1 = y1; r.color = c;
      return r;
   endfunction

   task automatic drive_a(input logic v, input logic [1:0] idx, input region_t r);
      a_valid = v; a_idx = idx; a_en = r.en;
      a_x0 = r.x0; a_x1 = r.x1; a_y0 = r.y0; a_y1 = r.y1; a_color = r.color;
   endtask

   task automatic drive_b(input logic v, input logic [1:0] idx, input region_t r);
      b_valid = v; b_idx = idx; b_en = r.en;
      b_x0 = r.x0; b_x1 = r.x1; b_y0 = r.y0; b_y1 = r.y1; b_color = r.color;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      region_t r_a, r_b, r_new, r_bad, r_bad2, r_c;
      r_a    = mk(1'b1, 11'd10, 11'd20, 11'd30, 11'd40, 12'h0F0);
      r_b    = mk(1'b1, 11'd100, 11'd200, 11'd300, 11'd400, 12'h00F);
      r_new  = mk(1'b1, 11'd250, 11'd750, 11'd50, 11'd150, 12'h800);
      r_bad  = mk(1'b1, 11'd760, 11'd750, 11'd50, 11'd150, 12'h00F);
      r_bad2 = mk(1'b1, 11'd0, 11'd800, 11'd0, 11'd10, 12'h0A0);
      r_c    = mk(1'b1, 11'd5, 11'd6, 11'd7, 11'd8, 12'h123);

      vecs[0] = '{"ok_basic",    mk(1'b1, 11'd250, 11'd750, 11'd50, 11'd150, 12'h800), 1'b1};
      vecs[1] = '{"x0_gt_x1",    mk(1'b1, 11'd760, 11'd750, 11'd50, 11'd150, 12'h800), 1'b0};
      vecs[2] = '{"y0_gt_y1",    mk(1'b1, 11'd0, 11'd10, 11'd151, 11'd150, 12'h111), 1'b0};
      vecs[3] = '{"x1_eq_800",   mk(1'b1, 11'd0, 11'd800, 11'd0, 11'd10, 12'h222), 1'b0};
      vecs[4] = '{"y1_eq_600",   mk(1'b1, 11'd0, 11'd10, 11'd0, 11'd600, 12'h333), 1'b0};
      vecs[5] = '{"edge_799_599", mk(1'b1, 11'd799, 11'd799, 11'd599, 11'd599, 12'hFFF), 1'b1};
      vecs[6] = '{"zero_point",  mk(1'b1, 11'd0, 11'd0, 11'd0, 11'd0, 12'h000), 1'b1};

      // Reset held for three cycles with A requesting
      rst = 1'b1; in_vblank = 1'b0;
      drive_a(1'b1, 2'd0, r_a);
      drive_b(1'b0, 2'd0, '0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_a_ready", 64'(a_ready), 64'd0);
         chk("rst_live_en", 64'({live_tbl[3].en, live_tbl[2].en, live_tbl[1].en, live_tbl[0].en}), 64'd0);
      end
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_commit_done", 64'(commit_done), 64'd0);
      chk("rst_err", 64'(err_invalid), 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_a_ready", 64'(a_ready), 64'd1);
      drive_a(1'b0, 2'd0, r_a);
      tick();

      // Fairness: both requesting, alternate starting with A
      drive_a(1'b1, 2'd0, r_a);
      drive_b(1'b1, 2'd1, r_b);
      #1;
      for (int k = 0; k < 6; k++) begin
         chk("fair_a_ready", 64'(a_ready), 64'((k % 2) == 0));
         chk("fair_b_ready", 64'(b_ready), 64'((k % 2) == 1));
         tick();
      end
      drive_a(1'b0, 2'd0, '0);
      drive_b(1'b0, 2'd0, '0);
      chk("fair_err", 64'(err_invalid), 64'd0);

      // Flush the fairness writes into the live table
      in_vblank = 1'b1;
      tick();
      chk("flush_busy", 64'(busy), 64'd1);
      chk("flush_ready", 64'(a_ready), 64'd0);
      repeat (4) tick();
      chk("flush_done", 64'(commit_done), 64'd1);
      chk("flush_live0", 64'(live_tbl[0]), 64'(r_a));
      chk("flush_live1", 64'(live_tbl[1]), 64'(r_b));
      in_vblank = 1'b0;
      tick();

      // Commit timing for a write to entry 1 during active video
      drive_a(1'b1, 2'd1, r_new);
      tick();
      drive_a(1'b0, 2'd0, '0);
      chk("pre_vb_live1", 64'(live_tbl[1]), 64'(r_b));
      tick(); tick();
      chk("pre_vb_live1_hold", 64'(live_tbl[1]), 64'(r_b));
      in_vblank = 1'b1;
      tick();   // edge t
      chk("t_busy", 64'(busy), 64'd1);
      chk("t_a_ready", 64'(a_ready), 64'd0);
      chk("t_b_ready", 64'(b_ready), 64'd0);
      chk("t_live1", 64'(live_tbl[1]), 64'(r_b));
      tick();   // t+1
      chk("t1_live1", 64'(live_tbl[1]), 64'(r_b));
      chk("t1_done", 64'(commit_done), 64'd0);
      tick();   // t+2
      chk("t2_live1", 64'(live_tbl[1]), 64'(r_new));
      tick();   // t+3
      chk("t3_done", 64'(commit_done), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      tick();   // t+4
      chk("t4_done", 64'(commit_done), 64'd1);
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_a_ready", 64'(a_ready), 64'd1);
      tick();   // t+5
      chk("t5_done", 64'(commit_done), 64'd0);
      chk("t5_live0", 64'(live_tbl[0]), 64'(r_a));
      in_vblank = 1'b0;
      tick();

      // Rejected descriptors, then a vblank rise with nothing staged
      drive_a(1'b1, 2'd2, r_bad);
      #1;
      chk("bad_a_ready", 64'(a_ready), 64'd1);
      tick();
      drive_a(1'b0, 2'd0, '0);
      chk("bad_err", 64'(err_invalid), 64'd1);
      drive_a(1'b1, 2'd3, r_bad2);
      tick();
      drive_a(1'b0, 2'd0, '0);
      tick();
      chk("bad_err_sticky", 64'(err_invalid), 64'd1);
      in_vblank = 1'b1;
      tick();
      chk("noop_busy", 64'(busy), 64'd0);
      chk("noop_a_ready", 64'(a_ready), 64'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("noop_done", 64'(commit_done), 64'd0);
         chk("noop_busy_hold", 64'(busy), 64'd0);
      end
      chk("noop_live2", 64'(live_tbl[2]), 64'd0);
      chk("noop_live3", 64'(live_tbl[3]), 64'd0);
      chk("noop_err", 64'(err_invalid), 64'd1);
      in_vblank = 1'b0;
      tick();

      // Reset lands on edge t+2 of a commit
      drive_a(1'b1, 2'd3, r_c);
      tick();
      drive_a(1'b0, 2'd0, '0);
      in_vblank = 1'b1;
      tick();   // edge t
      chk("mid_busy", 64'(busy), 64'd1);
      tick();   // t+1
      chk("mid_live0", 64'(live_tbl[0]), 64'(r_a));
      rst = 1'b1;
      tick();   // t+2 with reset
      for (int i = 0; i < 4; i++) begin
         chk("mid_rst_live", 64'(live_tbl[i]), 64'd0);
      end
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_err", 64'(err_invalid), 64'd0);
      rst = 1'b0;
      in_vblank = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_rst_no_done", 64'(commit_done), 64'd0);
         chk("mid_rst_idle", 64'(busy), 64'd0);
      end

      // Validation table: each vector written by B to entry 2 after a fresh reset
      for (int v = 0; v < 7; v++) begin
         rst = 1'b1; in_vblank = 1'b0;
         drive_a(1'b0, 2'd0, '0);
         drive_b(1'b0, 2'd0, '0);
         tick();
         rst = 1'b0;
         drive_b(1'b1, 2'd2, vecs[v].d);
         tick();
         drive_b(1'b0, 2'd0, '0);
         tick();
         chk({vecs[v].name, "_err"}, 64'(err_invalid), 64'(!vecs[v].ok));
         in_vblank = 1'b1;
         tick();
         repeat (4) tick();
         chk({vecs[v].name, "_done"}, 64'(commit_done), 64'(vecs[v].ok));
         chk({vecs[v].name, "_live2"}, 64'(live_tbl[2]),
             vecs[v].ok ? 64'(vecs[v].d) : 64'd0);
         in_vblank = 1'b0;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
